// File: rtl/pic_fifo_port.sv
// ADC-to-PIC parallel master port bridge: sample FIFO plus a dreq/drdy beat
// handshake that serialises each sample LSB-first in PMP_W-bit beats.
module pic_fifo_port #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PMP_W  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SETUP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     adc_valid,
  input  logic                     pmp_dreq,
  output logic [PMP_W-1:0]         pmp_d,
  output logic                     pmp_drdy,
  output logic                     pmp_empty,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned BEATS  = DATA_W / PMP_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = (SETUP > 1) ? $clog2(SETUP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              r_sync1, r_dreq_s, r_dreq_d;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic [DATA_W-1:0] r_hold;
  logic [PMP_W-1:0]  r_pmp_d;
  logic              r_drdy, r_empty;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [DATA_W-1:0] w_hold_nxt;
  logic [PMP_W-1:0]  w_d_nxt;
  logic              w_drdy_nxt, w_empty_nxt, w_pop;
  logic              w_rise, w_fifo_empty, w_full, w_push_ok, w_drop, w_last;
  logic [DATA_W-1:0] w_head, w_src;
  logic [PMP_W-1:0]  w_beat_data;

  assign w_rise       = r_dreq_s & ~r_dreq_d;
  assign w_fifo_empty = (r_level == '0);
  assign w_full       = (r_level == LVL_W'(DEPTH));
  assign w_push_ok    = adc_valid & (~w_full | w_pop);
  assign w_drop       = adc_valid & w_full & ~w_pop;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_last       = (r_beat == BEAT_W'(BEATS - 1));
  // Beat 0 reads the FIFO head directly; later beats come from the hold copy.
  assign w_src        = (r_beat == '0) ? w_head : r_hold;
  assign w_beat_data  = PMP_W'(w_src >> (32'(r_beat) * PMP_W));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_hold_nxt  = r_hold;
    w_d_nxt     = r_pmp_d;
    w_drdy_nxt  = r_drdy;
    w_empty_nxt = r_empty;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_d_nxt    = '0;
        w_drdy_nxt = 1'b0;
        if (w_rise) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          if ((r_beat == '0) && w_fifo_empty) begin
            w_empty_nxt = 1'b1;
          end else begin
            w_empty_nxt = 1'b0;
            w_d_nxt     = w_beat_data;
            if (r_beat == '0) w_hold_nxt = w_head;
          end
        end
      end
      S_SETUP: begin
        if (!r_dreq_s) begin
          w_state_nxt = S_IDLE;
          w_d_nxt     = '0;
          w_empty_nxt = 1'b0;
        end else if (r_cnt == CNT_W'(SETUP - 1)) begin
          w_state_nxt = S_READY;
          w_drdy_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_READY: begin
        if (!r_dreq_s) begin
          w_state_nxt = S_IDLE;
          w_drdy_nxt  = 1'b0;
          w_d_nxt     = '0;
          w_empty_nxt = 1'b0;
          if (!r_empty) begin
            if (w_last) begin
              w_pop      = 1'b1;
              w_beat_nxt = '0;
            end else begin
              w_beat_nxt = r_beat + BEAT_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_dreq_s   <= 1'b0;
      r_dreq_d   <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_hold     <= '0;
      r_pmp_d    <= '0;
      r_drdy     <= 1'b0;
      r_empty    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1  <= pmp_dreq;
      r_dreq_s <= r_sync1;
      r_dreq_d <= r_dreq_s;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_beat   <= w_beat_nxt;
      r_hold   <= w_hold_nxt;
      r_pmp_d  <= w_d_nxt;
      r_drdy   <= w_drdy_nxt;
      r_empty  <= w_empty_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
      // A drop wins over a same-cycle clear.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= adc_data;
  end

  assign pmp_d      = r_pmp_d;
  assign pmp_drdy   = r_drdy;
  assign pmp_empty  = r_empty;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule
